word_stream_packer: RTL and testbench
=====================================

Name: word_stream_packer

Overview:
- Word-serial ingress stage that sits directly upstream of the bits-to-columns/rows unpack stage.
- Accepts 32-bit words on a valid/ready stream and assembles them into one SIZE-bit block (plaintext, ciphertext or key).
- Presents the block on a registered valid/ready output.
- Double-buffered: an accumulator fills while the previous block is held on the output, so sustained throughput is one word per clock.

Parameters:
- SIZE, 128, block width in bits; legal values 128, 192, 256.
- COL_NUM, SIZE/32, words per block; derived, not overridden.
- CNT_W, $clog2(COL_NUM)+1, word counter width; derived.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  packer accepts in_word this cycle.
- in_word  input  32  column word; byte 0 (row0) in bits [7:0].
- in_last  input  1  marks the final word of a block.
- flush  input  1  synchronous discard of the partial block.
- out_valid  output  1  out_block holds a complete block.
- out_ready  input  1  downstream consumes out_block.
- out_block  output  SIZE  assembled block; word k lands at [32*k +: 32].
- err_short  output  1  one-cycle pulse: in_last arrived before word COL_NUM-1.

Behaviour:
- Reset (asynchronous): count=0, acc_full=0, out_valid=0, err_short=0, out_block=0, accumulator=0.
- in_ready is combinational: !acc_full || (out_valid==0) || out_ready.
- Input handshake: in_valid && in_ready transfers a word.
  - The word is written to acc[32*count +: 32].
  - count increments.
  - The k-th accepted word of a block maps to column k, matching the downstream cols[k].
- Completion: a word is accepted at count==COL_NUM-1 (in_last ignored at this index).
  - Output free (out_valid==0, or out_ready==1 this cycle): out_block gets the full block, including the current word, on the next edge; out_valid=1; count=0.
  - Output busy: acc_full=1, count=0, in_ready drops.
- Latency: last word accepted at edge t gives out_valid=1 after edge t. No combinational path from in_word to out_block.
- Draining a full accumulator: acc_full && out_valid && out_ready gives out_block<=acc, out_valid stays 1, acc_full=0. in_ready is already 1 that cycle, so a new word 0 may be accepted simultaneously into the cleared accumulator.
- Output handshake: out_valid && out_ready with nothing pending gives out_valid=0 next cycle. out_block holds its value until replaced; it is never cleared except by reset.
- While out_valid=1 && !out_ready, out_block is stable.
- Short frame: in_last accepted at count<COL_NUM-1.
  - err_short pulses high for the next cycle.
  - The partial block is dropped and count=0.
  - Nothing reaches the output.
- flush:
  - Next edge: count=0 and any partial accumulation is discarded.
  - If acc_full=1, the held complete block is kept.
  - out_valid and out_block are unaffected.
  - An in_valid word presented in the same cycle as flush is not accepted (in_ready is forced low while flush=1).
- Simultaneous events:
  - flush and an output handshake are independent and both take effect.
  - Completion and a same-cycle output handshake perform load-through (no bubble).
- Reset mid-block: asynchronous clear; a subsequent block starts at column 0.
- Counter never exceeds COL_NUM-1; no wrap beyond the block.

Decomposition:
- Shared aes_pkg holds:
  - WORD_W=32 and BYTE_W=8.
  - The legal block-size constants (128/192/256).
  - A function words_per_block(size).
- No sub-module: the accumulator, counter and output register are a single always_ff set plus in_ready logic.
- out_block feeds bits2cols/bits2rows unchanged.

Test Plan:
- Basic fill, SIZE=128: words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C (last on the 4th), out_ready=1 -> out_valid rises the cycle after word 3, out_block=0x0F0E0D0C_0B0A0908_07060504_03020100, downstream row0=0x0C080400.
- Back-pressure: out_ready=0, send two blocks back-to-back -> the first block is held stable, in_ready falls after the second block's 4th word; raise out_ready -> the second block appears the next cycle, then out_valid drops; no data lost.
- Sustained streaming: in_valid=1 and out_ready=1 continuously for 8 blocks -> one out_valid pulse every 4 cycles, in_ready always 1, all blocks correct and in order.
- Short frame: in_last on word 2 -> err_short=1 for exactly one cycle, no out_valid; the next 4 words form a correct block at column 0.
- flush after 2 words, then 4 fresh words -> output contains only the fresh words. Also assert rst asynchronously mid-block -> outputs are 0 immediately and recovery is clean.
- SIZE=256: 8 words 0x00000000..0x00000007 -> out_block[32*k +: 32]=k for all k, out_valid after the 8th word.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants for the block-cipher datapath front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_pkg;

    localparam int WORD_W   = 32;
    localparam int BYTE_W   = 8;

    // Legal block sizes for plaintext/ciphertext/key blocks.
    localparam int SIZE_128 = 128;
    localparam int SIZE_192 = 192;
    localparam int SIZE_256 = 256;

    // Number of 32-bit column words that make up one block.
    function automatic int words_per_block(input int size);
        return size / WORD_W;
    endfunction

endpackage

// File: rtl/word_stream_packer.sv
// Purpose: packs a 32-bit word stream into one SIZE-bit block, word k at [32*k +: 32].
// Latency: block presented on the edge that accepts its final word; one word per clock sustained.
// Backpressure: one block held on the output plus one in the accumulator; in_ready drops when both are occupied.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/in_word      word input stream
//   in_last                        end-of-block marker (only meaningful before the final column)
//   flush                          synchronous discard of a partial block
//   out_valid/out_ready/out_block  registered block output stream
//   err_short                      one-cycle pulse when in_last ends a block early
module word_stream_packer
    import aes_pkg::*;
#(
    parameter int SIZE = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_word,
    input  logic            in_last,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_block,
    output logic            err_short
);

    localparam int COL_NUM = words_per_block(SIZE);
    localparam int CNT_W   = $clog2(COL_NUM) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COL_NUM - 1);

    logic [CNT_W-1:0] r_count;
    logic [SIZE-1:0]  r_acc;
    logic             r_acc_full;
    logic             r_out_valid;
    logic [SIZE-1:0]  r_out_block;
    logic             r_err_short;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_free;
    logic             w_drain;
    logic             w_complete;
    logic             w_short;
    logic [SIZE-1:0]  w_acc_ins;

    // The output slot is free for a new block if it is empty or being consumed now.
    assign w_out_free = !r_out_valid || out_ready;

    // A held complete block moves to the output as soon as the current one is taken.
    assign w_drain    = r_acc_full && r_out_valid && out_ready;

    assign w_in_ready = !flush && (!r_acc_full || !r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_complete = w_accept && (r_count == LAST_IDX);
    assign w_short    = w_accept && in_last && (r_count != LAST_IDX);

    // Accumulator with the current word inserted; on a drain the accumulator is
    // emptied in the same cycle, so the new word lands in a cleared block.
    always_comb begin
        w_acc_ins = w_drain ? '0 : r_acc;
        w_acc_ins[WORD_W*r_count +: WORD_W] = in_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_acc       <= '0;
            r_acc_full  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
            r_err_short <= 1'b0;
        end else begin
            r_err_short <= w_short;

            // Word counter: restarts on flush, short frame or completion.
            if (flush || w_short || w_complete) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + 1'b1;
            end

            // Output register. Drain and completion cannot coincide: a drain
            // only happens with the counter at column 0.
            if (w_drain) begin
                r_out_block <= r_acc;
                r_out_valid <= 1'b1;
            end else if (w_complete && w_out_free) begin
                r_out_block <= w_acc_ins;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_drain) begin
                r_acc_full <= 1'b0;
            end

            // Accumulator. A complete block parks here only when the output is busy.
            if (w_complete && !w_out_free) begin
                r_acc      <= w_acc_ins;
                r_acc_full <= 1'b1;
            end else if (w_complete || w_short) begin
                r_acc <= '0;
            end else if (w_accept) begin
                r_acc <= w_acc_ins;
            end else if (flush && !r_acc_full) begin
                r_acc <= '0;
            end else if (w_drain) begin
                r_acc <= '0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;
    assign err_short = r_err_short;

endmodule

// File: tb/tb_word_stream_packer.sv
// Bench for word_stream_packer: behavioural two-slot block model plus directed literal checks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_word_stream_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_last, flush, out_valid, out_ready, err_short;
    logic [31:0]  in_word;
    logic [127:0] out_block;

    logic         b_in_valid, b_in_ready, b_in_last, b_out_valid, b_err_short;
    logic [31:0]  b_in_word;
    logic [255:0] b_out_block;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    word_stream_packer #(.SIZE(128)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_last(in_last), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .err_short(err_short)
    );

    word_stream_packer #(.SIZE(256)) dut256 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_word(b_in_word), .in_last(b_in_last), .flush(1'b0),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_block(b_out_block),
        .err_short(b_err_short)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Up to two completed blocks may be outstanding (one shown, one waiting).
    logic [127:0] q[$];
    logic [31:0]  words[$];
    logic         exp_err = 1'b0;

    always @(negedge clk) begin
        logic         exp_rdy;
        logic [127:0] blk;
        if (rst) begin
            q.delete();
            words.delete();
            exp_err = 1'b0;
            chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
            chk("rst_out_block", {128'd0, out_block}, 256'd0);
            chk("rst_err_short", {255'd0, err_short}, 256'd0);
        end else begin
            exp_rdy = !flush && (q.size() < 2 || out_ready);
            chk("m_in_ready",  {255'd0, in_ready},  {255'd0, exp_rdy});
            chk("m_out_valid", {255'd0, out_valid}, {255'd0, (q.size() != 0)});
            if (q.size() != 0)
                chk("m_out_block", {128'd0, out_block}, {128'd0, q[0]});
            chk("m_err_short", {255'd0, err_short}, {255'd0, exp_err});
            // state after the coming edge
            exp_err = 1'b0;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (flush) begin
                words.delete();
            end else if (in_valid && exp_rdy) begin
                words.push_back(in_word);
                if (words.size() == 4) begin
                    blk = '0;
                    for (int k = 0; k < 4; k++) blk[32*k +: 32] = words[k];
                    q.push_back(blk);
                    words.delete();
                end else if (in_last) begin
                    exp_err = 1'b1;
                    words.delete();
                end
            end
        end
    end

    // ---------------- streaming monitor ----------------
    logic strm = 1'b0;
    int   low_cnt = 0;
    int   vld_cnt = 0;
    always @(negedge clk) begin
        if (strm) begin
            if (!in_ready) low_cnt <= low_cnt + 1;
            if (out_valid) vld_cnt <= vld_cnt + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [31:0] w, input logic last);
        int n = 0;
        in_valid = 1'b1; in_word = w; in_last = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL send_timeout: in_ready stayed %0b for %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_blk(input logic [31:0] base);
        for (int k = 0; k < 4; k++) send(base + 32'(k), k == 3);
    endtask

    logic rnd_on = 1'b0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1; in_valid = 0; in_word = 0; in_last = 0; flush = 0; out_ready = 1;
        b_in_valid = 0; b_in_word = 0; b_in_last = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  {255'd0, in_ready},  256'd1);
        chk("reset_out_block", {128'd0, out_block}, 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic fill
        send(32'h03020100, 0); send(32'h07060504, 0); send(32'h0B0A0908, 0);
        chk("fill_not_yet", {255'd0, out_valid}, 256'd0);
        send(32'h0F0E0D0C, 1);
        chk("fill_valid", {255'd0, out_valid}, 256'd1);
        chk("fill_block", {128'd0, out_block}, {128'd0, 128'h0F0E0D0C_0B0A0908_07060504_03020100});
        chk("fill_row0", {224'd0, out_block[103:96], out_block[71:64], out_block[39:32], out_block[7:0]},
            {224'd0, 32'h0C080400});
        @(posedge clk); #1;

        // back-pressure
        out_ready = 1'b0;
        send_blk(32'hA0000000);
        send_blk(32'hB0000000);
        chk("bp_in_ready_low", {255'd0, in_ready}, 256'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_a", {128'd0, out_block}, {128'd0, 128'hA0000003_A0000002_A0000001_A0000000});
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_b", {255'd0, out_valid}, 256'd1);
        chk("bp_block_b", {128'd0, out_block}, {128'd0, 128'hB0000003_B0000002_B0000001_B0000000});
        @(posedge clk); #1;
        chk("bp_drop", {255'd0, out_valid}, 256'd0);

        // sustained streaming
        c0 = cyc; strm = 1'b1;
        for (int b = 0; b < 8; b++) send_blk(32'hC0000000 | (32'(b) << 8));
        chk("strm_cycles", 256'(cyc - c0), 256'd32);
        @(negedge clk); #1;
        strm = 1'b0;
        chk("strm_rdy_low", 256'(low_cnt), 256'd0);
        chk("strm_pulses", 256'(vld_cnt), 256'd8);
        @(posedge clk); #1;

        // short frame
        send(32'h11111110, 0); send(32'h11111111, 0); send(32'h11111112, 1);
        chk("short_err", {255'd0, err_short}, 256'd1);
        chk("short_no_out", {255'd0, out_valid}, 256'd0);
        @(posedge clk); #1;
        chk("short_err_pulse", {255'd0, err_short}, 256'd0);
        send_blk(32'hD0000000);
        chk("short_next", {128'd0, out_block}, {128'd0, 128'hD0000003_D0000002_D0000001_D0000000});
        @(posedge clk); #1;

        // flush after two words, with a word offered during the flush cycle
        send(32'hEEEE0000, 0); send(32'hEEEE0001, 0);
        flush = 1'b1; in_valid = 1'b1; in_word = 32'hDEADBEEF;
        #1;
        chk("flush_rdy_low", {255'd0, in_ready}, 256'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        send_blk(32'hF0000000);
        chk("flush_block", {128'd0, out_block}, {128'd0, 128'hF0000003_F0000002_F0000001_F0000000});
        @(posedge clk); #1;

        // asynchronous reset mid-block with a block held on the output
        out_ready = 1'b0;
        send_blk(32'h60000000);
        send(32'h70000000, 0); send(32'h70000001, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {255'd0, out_valid}, 256'd0);
        chk("arst_block", {128'd0, out_block}, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        send_blk(32'h80000000);
        chk("arst_recover", {128'd0, out_block}, {128'd0, 128'h80000003_80000002_80000001_80000000});
        @(posedge clk); #1;

        // SIZE=256
        for (int k = 0; k < 8; k++) begin
            b_in_valid = 1'b1; b_in_word = 32'(k); b_in_last = (k == 7);
            #1;
            chk("w256_ready", {255'd0, b_in_ready}, 256'd1);
            chk("w256_not_yet", {255'd0, b_out_valid}, 256'd0);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("w256_valid", {255'd0, b_out_valid}, 256'd1);
        for (int k = 0; k < 8; k++)
            chk("w256_word", {224'd0, b_out_block[32*k +: 32]}, 256'(k));

        // randomized traffic against the model
        rnd_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 80; f++) begin
                    int len;
                    len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4;
                    for (int k = 0; k < len; k++) begin
                        if ($urandom_range(0, 19) == 0) begin
                            flush = 1'b1;
                            @(posedge clk); #1;
                            flush = 1'b0;
                        end
                        repeat ($urandom_range(0, 1)) begin
                            @(posedge clk); #1;
                        end
                        send($urandom, k == len - 1);
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_drained", {255'd0, out_valid}, 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
